rf_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32×32 register file (x0 hard-wired to zero). Shares the register file's single synchronous write port between the in-order pipeline writeback and a long-latency unit (multiply/divide or load-return), buffering long-latency results in a small FIFO. It also tracks destination registers with outstanding long-latency results and raises a read-stall for the decode stage.

---
 rtl/rf_ctrl_pkg.sv | 17 +
 rtl/rf_wb_fifo.sv | 61 ++++++
 rtl/rf_wb_arbiter.sv | 105 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | rf_ctrl_pkg : shared widths and writeback entry type   | Rev 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

package rf_ctrl_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wb_entry_t;
endpackage

`default_nettype wire

// File: rtl/rf_wb_fifo.sv
// +--------------------------------------------------------------------+
// | rf_wb_fifo : DEPTH-entry synchronous FIFO of writeback results  | Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module rf_wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  wb_entry_t                  push_data,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  // Guard against overflow/underflow so occupancy can never go out of range.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// +--------------------------------------------------------------------+
// | rf_wb_arbiter : RF write-port arbiter + long-latency scoreboard | Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module rf_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_wa,
  input  logic [DW-1:0] pipe_wd,
  input  logic          lu_issue,
  input  logic [AW-1:0] lu_issue_rd,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_wa,
  input  logic [DW-1:0] lu_wd,
  output logic          lu_ready,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          stall,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          err
);
  import rf_ctrl_pkg::*;

  wb_entry_t                  w_head;
  wb_entry_t                  w_push_data;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(DEPTH+1)-1:0] w_unused_count;
  logic                       w_pipe_wr;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_err_evt;
  logic [NREG-1:0]            w_set;
  logic [NREG-1:0]            w_clr;
  logic [NREG-1:0]            r_pending;
  logic                       r_err;

  // A pipeline write to x0 is not a real write, so it must not block the drain.
  assign w_pipe_wr   = pipe_we && (pipe_wa != '0);
  assign w_pop       = !w_empty && !w_pipe_wr;
  assign w_push      = lu_valid && !w_full;
  assign w_push_data = '{wa: lu_wa, wd: lu_wd};

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_unused_count)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_wa = w_head.wa;
    rf_wd = w_head.wd;
    if (w_pipe_wr) begin
      rf_we = 1'b1;
      rf_wa = pipe_wa;
      rf_wd = pipe_wd;
    end else if (w_pop) begin
      rf_we = (w_head.wa != '0);
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (lu_issue && (lu_issue_rd != '0)) w_set[lu_issue_rd] = 1'b1;
    if (w_pop)                            w_clr[w_head.wa]   = 1'b1;
  end

  // Re-issue to a register whose result drains on the same edge is legal.
  assign w_err_evt = (lu_issue && r_pending[lu_issue_rd] && !w_clr[lu_issue_rd])
                   | (w_pipe_wr && r_pending[pipe_wa])
                   | (lu_valid && w_full)
                   | (w_pop && !r_pending[w_head.wa]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~NREG'(1);
      r_err     <= r_err | w_err_evt;
    end
  end

  assign stall    = r_pending[ra1] | r_pending[ra2];
  assign lu_ready = !w_full;
  assign err      = r_err;
endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_rf_wb_arbiter : directed + random bench against a queue model | Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_we, lu_issue, lu_valid;
  logic [AW-1:0] pipe_wa, lu_issue_rd, lu_wa, ra1, ra2;
  logic [DW-1:0] pipe_wd, lu_wd;
  logic          lu_ready, stall, rf_we, err;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .ra1(ra1), .ra2(ra2), .stall(stall),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .err(err)
  );

  typedef struct {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } ent_t;

  int            n_assert = 0;
  int            n_fail   = 0;
  ent_t          q[$];
  bit            pend[32];
  bit            m_err;
  logic [AW-1:0] owed[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    owed.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic drive(input logic pwe, input logic [AW-1:0] pwa, input logic [DW-1:0] pwd,
                       input logic iss, input logic [AW-1:0] ird,
                       input logic lv, input logic [AW-1:0] lwa, input logic [DW-1:0] lwd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
    lu_issue = iss; lu_issue_rd = ird;
    lu_valid = lv; lu_wa = lwa; lu_wd = lwd;
    ra1 = a1; ra2 = a2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare every output against the model, then advance the model across the next edge.
  task automatic step(input string tag);
    bit            ready, pw, pop, ew, es;
    logic [AW-1:0] ewa;
    logic [DW-1:0] ewd;
    ent_t          e;
    #1;
    ready = (q.size() < DEPTH);
    pw    = pipe_we && (pipe_wa != 0);
    pop   = !pw && (q.size() > 0);
    ew    = pw || (pop && q[0].wa != 0);
    ewa   = pw ? pipe_wa : (pop ? q[0].wa : '0);
    ewd   = pw ? pipe_wd : (pop ? q[0].wd : '0);
    es    = (ra1 != 0 && pend[ra1]) || (ra2 != 0 && pend[ra2]);
    chk({tag, ":lu_ready"}, 32'(lu_ready), 32'(ready));
    chk({tag, ":stall"},    32'(stall),    32'(es));
    chk({tag, ":rf_we"},    32'(rf_we),    32'(ew));
    if (ew) begin
      chk({tag, ":rf_wa"}, 32'(rf_wa), 32'(ewa));
      chk({tag, ":rf_wd"}, rf_wd, ewd);
    end
    chk({tag, ":err"}, 32'(err), 32'(m_err));
    if (rst_n) begin
      if (lu_issue && lu_issue_rd != 0 && pend[lu_issue_rd] && !(pop && q[0].wa == lu_issue_rd)) m_err = 1'b1;
      if (pw && pend[pipe_wa])   m_err = 1'b1;
      if (lu_valid && !ready)    m_err = 1'b1;
      if (pop && !pend[q[0].wa]) m_err = 1'b1;
      if (pop) begin
        e = q.pop_front();
        pend[e.wa] = 1'b0;
      end
      if (lu_issue && lu_issue_rd != 0) pend[lu_issue_rd] = 1'b1;
      if (lu_valid && ready) q.push_back('{lu_wa, lu_wd});
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_clear();
    step(tag);
    step(tag);
    rst_n = 1'b1;
  endtask

  // Protocol-respecting random traffic: issue free regs, return owed results in order.
  task automatic rand_legal();
    logic          pwe, iss, lv;
    logic [AW-1:0] pwa, ird, lwa;
    pwe = 1'($urandom_range(0, 1));
    pwa = 5'($urandom_range(0, 31));
    if (pend[pwa]) pwa = '0;
    iss = ($urandom_range(0, 2) == 0);
    ird = 5'($urandom_range(1, 31));
    if (pend[ird]) iss = 1'b0;
    lv  = 1'b0;
    lwa = '0;
    if (owed.size() > 0 && q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
      lv  = 1'b1;
      lwa = owed.pop_front();
    end
    if (iss) owed.push_back(ird);
    drive(pwe, pwa, $urandom, iss, ird, lv, lwa, $urandom,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    step("rand_legal");
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_clear();
    @(negedge clk);
    step("rst");
    step("rst");
    rst_n = 1'b1;
    step("idle");
    #1;
    chk("idle:lu_ready", 32'(lu_ready), 32'd1);
    chk("idle:stall",    32'(stall),    32'd0);
    chk("idle:rf_we",    32'(rf_we),    32'd0);
    chk("idle:err",      32'(err),      32'd0);
    step("idle");

    // Single long-latency op to x5.
    drive(0, 0, 0, 1, 5, 0, 0, 0, 0, 0);            step("iss5");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);  #1 chk("stall5", 32'(stall), 32'd1); step("stall5");
    drive(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0); step("push5");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    chk("wr5:we", 32'(rf_we), 32'd1);
    chk("wr5:wa", 32'(rf_wa), 32'd5);
    chk("wr5:wd", rf_wd, 32'hDEADBEEF);
    step("wr5");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);  #1 chk("clr5", 32'(stall), 32'd0); step("clr5");

    // Pipeline hogs the port while two results fill the FIFO.
    drive(0, 0, 0, 1, 10, 0, 0, 0, 0, 0);           step("iss10");
    drive(0, 0, 0, 1, 11, 0, 0, 0, 0, 0);           step("iss11");
    drive(1, 3, 1, 0, 0, 1, 10, 32'hA10, 0, 0);     step("burst0");
    drive(1, 3, 2, 0, 0, 1, 11, 32'hA11, 0, 0);     step("burst1");
    drive(1, 3, 3, 0, 0, 0, 0, 0, 0, 0);  #1 chk("full:lu_ready", 32'(lu_ready), 32'd0); step("burst2");
    drive(1, 3, 4, 0, 0, 0, 0, 0, 0, 0);            step("burst3");
    idle();  #1 chk("drain0:wa", 32'(rf_wa), 32'd10); step("drain0");
    idle();  #1 chk("drain1:wa", 32'(rf_wa), 32'd11); step("drain1");
    step("drained");

    // Pipeline write to x0 does not block the drain.
    drive(0, 0, 0, 1, 7, 0, 0, 0, 0, 0);            step("iss7");
    drive(0, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0);       step("push7");
    drive(1, 0, 32'hBAD, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("x0pipe:we", 32'(rf_we), 32'd1);
    chk("x0pipe:wa", 32'(rf_wa), 32'd7);
    step("x0pipe");

    // Same-edge clear and set of x9, then a genuine re-issue violation.
    drive(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);            step("iss9");
    drive(0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0);       step("push9");
    drive(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);            step("pop_iss9");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    #1;
    chk("setwins:stall", 32'(stall), 32'd1);
    chk("setwins:err",   32'(err),   32'd0);
    step("setwins");
    drive(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);            step("reiss9");
    idle();  #1 chk("err_set", 32'(err), 32'd1);    step("err_set");
    step("err_hold");
    #1 chk("err_sticky", 32'(err), 32'd1);

    // Reset with buffered results and pending bits.
    drive(0, 0, 0, 1, 12, 0, 0, 0, 0, 0);           step("iss12");
    drive(1, 3, 0, 0, 0, 1, 12, 32'hC12, 0, 0);     step("fill0");
    drive(1, 3, 0, 0, 0, 1, 13, 32'hC13, 12, 0);    step("fill1");
    rst_n = 1'b0;
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
    #1;
    chk("midrst:stall",    32'(stall),    32'd0);
    chk("midrst:lu_ready", 32'(lu_ready), 32'd1);
    chk("midrst:err",      32'(err),      32'd0);
    step("midrst");
    rst_n = 1'b1;
    idle();
    step("postrst");

    // Everything pending, but x0 reads never stall; a wa=0 result drains silently.
    for (int r = 1; r < 32; r++) begin
      drive(0, 0, 0, 1, 5'(r), 0, 0, 0, 0, 0);
      step("iss_all");
    end
    idle();  #1 chk("x0read", 32'(stall), 32'd0);   step("x0read");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 31); #1 chk("r31read", 32'(stall), 32'd1); step("r31read");
    drive(0, 0, 0, 0, 0, 1, 0, 32'h5, 0, 0);        step("push_x0");
    idle();  #1 chk("drain_x0:we", 32'(rf_we), 32'd0); step("drain_x0");
    step("after_x0");

    // Random legal traffic, reset in the middle of it, then unconstrained traffic.
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) rand_legal();
    do_reset("rst_rand2");
    for (int i = 0; i < 200; i++) rand_legal();
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step("rand_free");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
